spi_slave_stream: RTL and testbench

Parametrised SPI slave for multi-word transfers. It supports all four SPI modes, a configurable word width and either bit order. TX and RX data pass through internal FIFOs with valid/ready streaming interfaces, so the host can keep many words in flight within one CS assertion. It sits between the external SPI pins and the on-chip bus logic, all in the `clk` domain.

---
 rtl/spi_stream_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/spi_slave_stream.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_slave_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_stream_pkg.sv
`timescale 1ns/1ps
// spi_stream_pkg
// Shared types and helpers for the streaming SPI slave:
//   spi_mode_t  - per-frame mode (cpol, cpha, msb_first) latched at CS fall
//   spi_edges_t - sample / shift strobes for the current sck edge
//   state_t     - frame state (idle / active)
//   edge_sel()  - maps leading/trailing strobes onto sample/shift for a cpha
//   LVL_W()     - width of a FIFO occupancy counter for a given depth
package spi_stream_pkg;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic msb_first;
   } spi_mode_t;

   typedef struct packed {
      logic sample;
      logic shift;
   } spi_edges_t;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   // cpha=0 samples on the leading edge and shifts on the trailing edge;
   // cpha=1 is the reverse.
   function automatic spi_edges_t edge_sel(input logic cpha,
                                           input logic lead,
                                           input logic trail);
      spi_edges_t e;
      e.sample = cpha ? trail : lead;
      e.shift  = cpha ? lead  : trail;
      return e;
   endfunction

   function automatic int unsigned LVL_W(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// sync_fifo
// First-word-fall-through synchronous FIFO with occupancy output.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push, din  - write strobe and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop        - read strobe; ignored while empty
//   dout       - head entry, valid while !empty (reads '0 when empty)
//   full/empty - status
//   level      - number of stored entries
module sync_fifo
   import spi_stream_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          din,
   input  logic                       pop,
   output logic [DATA_W-1:0]          dout,
   output logic                       full,
   output logic                       empty,
   output logic [LVL_W(DEPTH)-1:0]    level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = LVL_W(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem_q[rptr_q];
   assign level   = cnt_q;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + LW'(1);
         2'b01:   cnt_d = cnt_q - LW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/spi_slave_stream.sv
`timescale 1ns/1ps
// spi_slave_stream
// SPI slave (all four modes, either bit order) moving back-to-back words
// between the SPI pins and valid/ready streams through TX and RX FIFOs.
//   clk, rst              - system clock, synchronous active-high reset
//   sck, cs, mosi         - asynchronous SPI inputs (cs active-low)
//   miso                  - SPI data out, 'z while cs or rst is high
//   cpol, cpha, msb_first - mode, latched at CS fall, ignored while busy
//   tx_data/valid/ready   - TX stream into the TX FIFO
//   rx_data/valid/ready   - RX stream out of the RX FIFO (FWFT head)
//   tx_level, rx_level    - FIFO occupancy
//   busy                  - frame in progress
//   tx_underrun           - sticky: a word started with the TX FIFO empty
//   rx_overrun            - sticky: a received word was dropped (RX full)
//   frame_err             - one-cycle pulse: CS rose mid-word
//   clr_flags             - clears the sticky flags
module spi_slave_stream
   import spi_stream_pkg::*;
#(
   parameter int unsigned       DATA_W        = 8,
   parameter int unsigned       FIFO_DEPTH    = 4,
   parameter int unsigned       SYNC_STAGES   = 2,
   parameter logic [DATA_W-1:0] UNDERRUN_WORD = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sck,
   input  logic                           cs,
   input  logic                           mosi,
   output logic                           miso,
   input  logic                           cpol,
   input  logic                           cpha,
   input  logic                           msb_first,
   input  logic [DATA_W-1:0]              tx_data,
   input  logic                           tx_valid,
   output logic                           tx_ready,
   output logic [DATA_W-1:0]              rx_data,
   output logic                           rx_valid,
   input  logic                           rx_ready,
   output logic [LVL_W(FIFO_DEPTH)-1:0]   tx_level,
   output logic [LVL_W(FIFO_DEPTH)-1:0]   rx_level,
   output logic                           busy,
   output logic                           tx_underrun,
   output logic                           rx_overrun,
   output logic                           frame_err,
   input  logic                           clr_flags
);

   localparam int unsigned BW = $clog2(DATA_W);

   // synchronisers and edge detection
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_last_q, sck_last_d;
   logic                   cs_last_q, cs_last_d;
   logic                   sck_s, cs_s, mosi_s;
   logic                   cs_fall, cs_rise, lead, trail;

   // frame state
   state_t            st_q, st_d;
   spi_mode_t         mode_q, mode_d, mode_in, mode;
   spi_edges_t        edg;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic              oe_q, oe_d;
   logic              upend_q, upend_d;
   logic              txu_q, txu_d;
   logic              rxo_q, rxo_d;
   logic              ferr_q, ferr_d;
   logic              load_word;

   // FIFO interface
   logic              tx_pop, tx_full, tx_empty;
   logic [DATA_W-1:0] tx_dout;
   logic              rx_push, rx_full, rx_empty;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign cs_fall = cs_last_q & ~cs_s;
   assign cs_rise = ~cs_last_q & cs_s;

   always_comb begin
      mode_in.cpol      = cpol;
      mode_in.cpha      = cpha;
      mode_in.msb_first = msb_first;
   end

   assign mode  = (st_q == ST_ACTIVE) ? mode_q : mode_in;
   assign lead  = ~cs_s & (mode.cpol ? (sck_last_q & ~sck_s) : (~sck_last_q & sck_s));
   assign trail = ~cs_s & (mode.cpol ? (~sck_last_q & sck_s) : (sck_last_q & ~sck_s));
   assign edg   = edge_sel(mode.cpha, lead, trail);

   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_last_d  = sck_s;
      cs_last_d   = cs_s;

      st_d      = st_q;
      mode_d    = mode_q;
      bit_d     = bit_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      oe_d      = oe_q;
      upend_d   = upend_q;
      txu_d     = txu_q;
      rxo_d     = rxo_q;
      ferr_d    = 1'b0;
      load_word = 1'b0;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;

      // clear first so a set event later in this block wins
      if (clr_flags) begin
         txu_d = 1'b0;
         rxo_d = 1'b0;
      end

      if (cs_fall) begin
         st_d      = ST_ACTIVE;
         mode_d    = mode_in;
         bit_d     = '0;
         upend_d   = 1'b0;
         oe_d      = ~mode_in.cpha;
         load_word = ~mode_in.cpha;
      end else if (cs_rise) begin
         st_d    = ST_IDLE;
         bit_d   = '0;
         oe_d    = 1'b0;
         upend_d = 1'b0;
         ferr_d  = (bit_q != '0);
      end else begin
         // A shift edge with the counter at zero is the first edge of a new
         // word in both phases, so it loads instead of shifting.
         if (edg.shift) begin
            if (bit_q == '0) begin
               load_word = 1'b1;
            end else if (mode.msb_first) begin
               tx_sh_d = tx_sh_q << 1;
            end else begin
               tx_sh_d = tx_sh_q >> 1;
            end
            if (mode.cpha) begin
               oe_d = 1'b1;
            end
         end
         if (edg.sample) begin
            rx_sh_d = mode.msb_first ? {rx_sh_q[DATA_W-2:0], mosi_s}
                                     : {mosi_s, rx_sh_q[DATA_W-1:1]};
            // In cpha=0 the trailing edge of a frame's last word pre-loads a
            // word nobody will clock out; underrun is therefore flagged only
            // once the loaded word's first bit is actually sampled.
            if (bit_q == '0 && upend_q) begin
               txu_d = 1'b1;
            end
            upend_d = 1'b0;
            if (bit_q == BW'(DATA_W - 1)) begin
               bit_d   = '0;
               rx_push = 1'b1;
               if (rx_full && !rx_ready) begin
                  rxo_d = 1'b1;
               end
            end else begin
               bit_d = bit_q + BW'(1);
            end
         end
      end

      if (load_word) begin
         tx_pop  = ~tx_empty;
         tx_sh_d = tx_empty ? UNDERRUN_WORD : tx_dout;
         upend_d = tx_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_last_q  <= 1'b0;
         cs_last_q   <= 1'b1;
         st_q        <= ST_IDLE;
         mode_q      <= '0;
         bit_q       <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         oe_q        <= 1'b0;
         upend_q     <= 1'b0;
         txu_q       <= 1'b0;
         rxo_q       <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_last_q  <= sck_last_d;
         cs_last_q   <= cs_last_d;
         st_q        <= st_d;
         mode_q      <= mode_d;
         bit_q       <= bit_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         oe_q        <= oe_d;
         upend_q     <= upend_d;
         txu_q       <= txu_d;
         rxo_q       <= rxo_d;
         ferr_q      <= ferr_d;
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid & tx_ready),
      .din   (tx_data),
      .pop   (tx_pop),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty),
      .level (tx_level)
   );

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .din   (rx_sh_d),
      .pop   (rx_ready),
      .dout  (rx_data),
      .full  (rx_full),
      .empty (rx_empty),
      .level (rx_level)
   );

   assign tx_ready    = ~tx_full;
   assign rx_valid    = ~rx_empty;
   assign busy        = (st_q == ST_ACTIVE);
   assign tx_underrun = txu_q;
   assign rx_overrun  = rxo_q;
   assign frame_err   = ferr_q;
   assign miso        = (rst || cs || !oe_q) ? 1'bz
                        : (mode_q.msb_first ? tx_sh_q[DATA_W-1] : tx_sh_q[0]);

endmodule

// File: tb/tb_spi_slave_stream.sv
`timescale 1ns/1ps
module tb_spi_slave_stream;

   localparam int H = 60;   // SPI half period: 6 clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic       msb_first = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b0;
   logic       clr_flags = 1'b0;
   wire        miso;
   logic       tx_ready, rx_valid, busy, tx_underrun, rx_overrun, frame_err;
   logic [7:0] rx_data;
   logic [2:0] tx_level, rx_level;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] tx_sb[$];
   logic [7:0] rx_sb[$];
   logic [7:0] got;

   typedef struct {
      logic       cpol;
      logic       cpha;
      logic       msb;
      logic [7:0] tx;
      logic [7:0] mosi_w;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   spi_slave_stream #(
      .DATA_W        (8),
      .FIFO_DEPTH    (4),
      .SYNC_STAGES   (2),
      .UNDERRUN_WORD (8'hFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sck         (sck),
      .cs          (cs),
      .mosi        (mosi),
      .miso        (miso),
      .cpol        (cpol),
      .cpha        (cpha),
      .msb_first   (msb_first),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .tx_level    (tx_level),
      .rx_level    (rx_level),
      .busy        (busy),
      .tx_underrun (tx_underrun),
      .rx_overrun  (rx_overrun),
      .frame_err   (frame_err),
      .clr_flags   (clr_flags)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] d);
      @(negedge clk);
      check("tx_ready", 32'(tx_ready), 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic pop_rx(input string name, input logic [7:0] exp);
      int t = 0;
      @(negedge clk);
      while (!rx_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      check({name, "_valid"}, 32'(rx_valid), 1);
      check(name, 32'(rx_data), 32'(exp));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      @(negedge clk);
   endtask

   task automatic cs_begin(input logic pol, input logic ph, input logic msb);
      @(negedge clk);
      cpol      = pol;
      cpha      = ph;
      msb_first = msb;
      sck       = pol;
      repeat (4) @(negedge clk);
      cs = 1'b0;
      #H;
   endtask

   task automatic cs_end();
      #H;
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // SPI master: shifts nbits of txw out on mosi, returns what it saw on miso
   task automatic spi_xfer(input logic [7:0] txw, input int nbits, output logic [7:0] rxw);
      rxw = '0;
      for (int i = 0; i < nbits; i++) begin
         logic b;
         b = msb_first ? txw[7-i] : txw[i];
         if (!cpha) begin
            mosi = b;
            #H;
            sck = ~cpol;
            rxw = msb_first ? {rxw[6:0], miso} : {miso, rxw[7:1]};
            #H;
            sck = cpol;
         end else begin
            sck  = ~cpol;
            mosi = b;
            #H;
            sck = cpol;
            rxw = msb_first ? {rxw[6:0], miso} : {miso, rxw[7:1]};
            #H;
         end
      end
   endtask

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int fe;

      vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h12, 8'hA5, 8'h12};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h6E, 8'h81, 8'h6E};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h6E, 8'h81, 8'h6E};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h6E, 8'h81, 8'h6E};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'hE7, 8'h3C, 8'hE7};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_miso_z", 32'(miso === 1'bz), 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 1);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_tx_level", 32'(tx_level), 0);
      check("rst_rx_level", 32'(rx_level), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_flags", 32'({tx_underrun, rx_overrun, frame_err}), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      check("idle_miso_z", 32'(miso === 1'bz), 1);

      // mode 0, two words in one frame
      push_tx(8'hA5); tx_sb.push_back(8'hA5);
      push_tx(8'h3C); tx_sb.push_back(8'h3C);
      check("t1_tx_level", 32'(tx_level), 2);
      cs_begin(1'b0, 1'b0, 1'b1);
      spi_xfer(8'h12, 8, got); rx_sb.push_back(8'h12);
      check("t1_miso0", 32'(got), 32'(tx_sb.pop_front()));
      check("t1_busy_mid", 32'(busy), 1);
      spi_xfer(8'h34, 8, got); rx_sb.push_back(8'h34);
      check("t1_miso1", 32'(got), 32'(tx_sb.pop_front()));
      cs_end();
      check("t1_busy_end", 32'(busy), 0);
      check("t1_rx_level", 32'(rx_level), 2);
      check("t1_flags", 32'({tx_underrun, rx_overrun}), 0);
      pop_rx("t1_rx0", rx_sb.pop_front());
      pop_rx("t1_rx1", rx_sb.pop_front());

      // mode / bit-order table
      for (int i = 0; i < 6; i++) begin
         push_tx(vecs[i].tx);
         cs_begin(vecs[i].cpol, vecs[i].cpha, vecs[i].msb);
         spi_xfer(vecs[i].mosi_w, 8, got);
         cs_end();
         check($sformatf("vec%0d_miso", i), 32'(got), 32'(vecs[i].exp_miso));
         check($sformatf("vec%0d_rx_level", i), 32'(rx_level), 1);
         check($sformatf("vec%0d_underrun", i), 32'(tx_underrun), 0);
         pop_rx($sformatf("vec%0d_rx", i), vecs[i].exp_rx);
      end

      // TX underrun with empty FIFO
      check("t3_tx_level", 32'(tx_level), 0);
      cs_begin(1'b0, 1'b0, 1'b1);
      spi_xfer(8'h55, 8, got);
      cs_end();
      check("t3_miso", 32'(got), 32'hFF);
      check("t3_underrun", 32'(tx_underrun), 1);
      repeat (10) @(negedge clk);
      check("t3_underrun_sticky", 32'(tx_underrun), 1);
      pulse_clr();
      check("t3_underrun_clr", 32'(tx_underrun), 0);
      pop_rx("t3_rx", 8'h55);

      // RX overrun: six words into a four-entry FIFO with no consumer
      for (int k = 0; k < 4; k++) begin
         push_tx(8'h11 * (k + 1));
         tx_sb.push_back(8'h11 * (k + 1));
      end
      cs_begin(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         spi_xfer(8'hB0 + 8'(k), 8, got);
         if (k < 4) begin
            rx_sb.push_back(8'hB0 + 8'(k));
            check($sformatf("t4_miso%0d", k), 32'(got), 32'(tx_sb.pop_front()));
         end else begin
            check($sformatf("t4_miso%0d", k), 32'(got), 32'hFF);
         end
      end
      cs_end();
      check("t4_rx_level", 32'(rx_level), 4);
      check("t4_overrun", 32'(rx_overrun), 1);
      while (rx_sb.size() > 0) pop_rx("t4_rx", rx_sb.pop_front());
      check("t4_rx_drained", 32'(rx_level), 0);
      check("t4_overrun_sticky", 32'(rx_overrun), 1);
      pulse_clr();
      check("t4_flags_clr", 32'({tx_underrun, rx_overrun}), 0);

      // partial word: frame error, nothing pushed, consumed TX word not re-queued
      push_tx(8'h5A);
      cs_begin(1'b0, 1'b0, 1'b1);
      spi_xfer(8'hF0, 5, got);
      #H;
      cs = 1'b1;
      fe = 0;
      repeat (12) begin
         @(negedge clk);
         if (frame_err) fe++;
      end
      check("t5_frame_err_cycles", 32'(fe), 1);
      check("t5_rx_level", 32'(rx_level), 0);
      check("t5_tx_level", 32'(tx_level), 0);
      push_tx(8'hC3);
      cs_begin(1'b0, 1'b0, 1'b1);
      spi_xfer(8'h3D, 8, got);
      cs_end();
      check("t5_next_miso", 32'(got), 32'hC3);
      check("t5_no_ferr", 32'(frame_err), 0);
      pop_rx("t5_next_rx", 8'h3D);

      // reset mid-word
      push_tx(8'h11);
      push_tx(8'h22);
      cs_begin(1'b0, 1'b0, 1'b1);
      spi_xfer(8'hAA, 3, got);
      check("t6_tx_level_pre", 32'(tx_level), 1);
      check("t6_busy_pre", 32'(busy), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_miso_z", 32'(miso === 1'bz), 1);
      check("t6_tx_level", 32'(tx_level), 0);
      check("t6_rx_level", 32'(rx_level), 0);
      check("t6_busy", 32'(busy), 0);
      cs  = 1'b1;
      sck = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_tx_ready", 32'(tx_ready), 1);
      push_tx(8'h96);
      cs_begin(1'b0, 1'b0, 1'b1);
      spi_xfer(8'h69, 8, got);
      cs_end();
      check("t6_after_miso", 32'(got), 32'h96);
      check("t6_after_flags", 32'({tx_underrun, rx_overrun}), 0);
      pop_rx("t6_after_rx", 8'h69);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
